de_write_combiner: RTL and testbench



---
 rtl/de_write_combiner.sv | 179 +++++++++++++++++
 tb/tb_de_write_combiner.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_write_combiner.sv
// Write-combining buffer: merges engine byte writes into 32-bit words and queues them for memory.
// Optional idle-timeout push of a partially filled holding word: define WC_TIMEOUT_EN.
module de_write_combiner #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  input  logic        flush,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic [31:0] mem_w_data,
  output logic        mem_rnw,
  output logic        busy,
  output logic        err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 18 + 4 + 32;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [EW-1:0] IDLE_ENTRY = {18'd0, 4'b1111, 32'd0};

  logic          de_ack_reg;
  logic          hv_reg, hv_next;
  logic [17:0]   haddr_reg, haddr_next;
  logic [3:0]    hmask_reg, hmask_next;
  logic [31:0]   hdata_reg, hdata_next;
  logic [CW-1:0] count_reg, count_next, count_after_pop;
  logic [PW-1:0] wptr_reg, rptr_reg;
  logic          mem_req_reg;
  logic [EW-1:0] head_reg, head_next;
  logic          busy_reg;
  logic          err_reg;

  logic [EW-1:0] fifo_mem [DEPTH];

  logic          acc, rd_acc, wr_acc, pop, push;
  logic          addr_change, idle_push, room, timeout_hit;
  logic [31:0]   merged_data;
  logic [EW-1:0] hold_entry;

  // Byte-lane merge: an enabled lane takes the new byte, the rest keep the held byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_data[gi*8 +: 8] = de_nbyte[gi] ? hdata_reg[gi*8 +: 8]
                                                   : de_w_data[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    acc             = de_req & de_ack_reg;
    rd_acc          = acc & de_rnw;
    wr_acc          = acc & ~de_rnw & (de_nbyte != 4'b1111);
    pop             = (count_reg != '0) & mem_ack;
    count_after_pop = count_reg - CW'(pop);
    room            = count_after_pop < DEPTH_C;
    addr_change     = wr_acc & hv_reg & (de_addr != haddr_reg);
    idle_push       = ~wr_acc & hv_reg & room &
                      ((hmask_reg == 4'b0000) | flush | timeout_hit);
    push            = addr_change | idle_push;
    count_next      = count_after_pop + CW'(push);
    hold_entry      = {haddr_reg, hmask_reg, hdata_reg};
  end

  always_comb begin
    hv_next    = hv_reg;
    haddr_next = haddr_reg;
    hmask_next = hmask_reg;
    hdata_next = hdata_reg;
    if (wr_acc) begin
      hv_next = 1'b1;
      if (!hv_reg || addr_change) begin
        haddr_next = de_addr;
        hmask_next = de_nbyte;
        hdata_next = de_w_data;
      end else begin
        hmask_next = hmask_reg & de_nbyte;
        hdata_next = merged_data;
      end
    end else if (idle_push) begin
      hv_next = 1'b0;
    end
  end

  // The head register tracks whatever will sit at the FIFO head after this edge,
  // including a word pushed into an empty (or just-emptied) FIFO.
  always_comb begin
    if (count_next == '0)
      head_next = IDLE_ENTRY;
    else if (count_after_pop == '0)
      head_next = hold_entry;
    else
      head_next = fifo_mem[rptr_reg + PW'(pop)];
  end

`ifdef WC_TIMEOUT_EN
  // The push fires on the edge where the timer would reach TIMEOUT; if the FIFO is
  // full the timer holds there until room appears.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer_reg, timer_next;

  always_comb begin
    timeout_hit = hv_reg & (timer_reg >= TIMER_LAST);
    timer_next  = timer_reg;
    if (wr_acc || idle_push)
      timer_next = 8'd0;
    else if (hv_reg && !timeout_hit)
      timer_next = timer_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer_reg <= 8'd0;
    else
      timer_reg <= timer_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_ack_reg  <= 1'b0;
      hv_reg      <= 1'b0;
      haddr_reg   <= 18'd0;
      hmask_reg   <= 4'b1111;
      hdata_reg   <= 32'd0;
      count_reg   <= '0;
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      mem_req_reg <= 1'b0;
      head_reg    <= IDLE_ENTRY;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      de_ack_reg  <= de_req & ~flush & (count_next < DEPTH_C);
      hv_reg      <= hv_next;
      haddr_reg   <= haddr_next;
      hmask_reg   <= hmask_next;
      hdata_reg   <= hdata_next;
      count_reg   <= count_next;
      if (push)
        wptr_reg <= wptr_reg + PW'(1);
      if (pop)
        rptr_reg <= rptr_reg + PW'(1);
      mem_req_reg <= (count_next != '0);
      head_reg    <= head_next;
      busy_reg    <= hv_next | (count_next != '0);
      if (rd_acc)
        err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr_reg] <= hold_entry;
  end

  assign de_ack     = de_ack_reg;
  assign de_r_data  = 32'd0;
  assign mem_req    = mem_req_reg;
  assign mem_addr   = head_reg[53:36];
  assign mem_nbyte  = head_reg[35:32];
  assign mem_w_data = head_reg[31:0];
  assign mem_rnw    = 1'b0;
  assign busy       = busy_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_de_write_combiner.sv
// Directed bench for de_write_combiner: table of write bursts plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_de_write_combiner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;
  logic        flush;
  logic        mem_req;
  logic        mem_ack;
  logic [17:0] mem_addr;
  logic [3:0]  mem_nbyte;
  logic [31:0] mem_w_data;
  logic        mem_rnw;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  de_write_combiner #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
    .flush(flush),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_nbyte(mem_nbyte),
    .mem_w_data(mem_w_data), .mem_rnw(mem_rnw),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [2:0]        nw;
    logic [3:0][17:0]  a;
    logic [3:0][3:0]   nb;
    logic [3:0][31:0]  d;
    logic [1:0]        ne;
    logic [2:0][53:0]  e;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  logic [53:0] got_q [$];

  // Memory-side monitor: a pop happens on the next rising edge when req and ack are both high.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && mem_req && mem_ack) begin
      got_q.push_back({mem_addr, mem_nbyte, mem_w_data});
      $display("mem write addr=%h nbyte=%b data=%h", mem_addr, mem_nbyte, mem_w_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [3:0] nb,
                          input logic [31:0] d, input logic rnw);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    @(negedge clk);
    de_req    = 1'b1;
    de_addr   = a;
    de_nbyte  = nb;
    de_w_data = d;
    de_rnw    = rnw;
    while (!done) begin
      if (de_ack) done = 1;
      @(posedge clk);
      n++;
      if (!done) begin
        if (n > 300) begin
          checks++;
          errors++;
          $display("FAIL write_timeout: addr %h never accepted", a);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    @(negedge clk);
    de_req = 1'b0;
    flush  = 1'b1;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!busy && !mem_req) idle = 1;
    end
    flush = 1'b0;
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy=%b mem_req=%b", busy, mem_req);
    end
  endtask

  task automatic bp_stream();
    for (int k = 0; k < 6; k++)
      do_write(18'h00100 + 18'(k), 4'b0000, 32'hA000_0000 + 32'(k), 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de_ack"},     de_ack,     0);
    check({tag, "_mem_req"},    mem_req,    0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_mem_nbyte"},  mem_nbyte,  4'b1111);
    check({tag, "_mem_w_data"}, mem_w_data, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_err"},        err,        0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '0;
    vecs[0].nw = 4;
    vecs[0].a[0] = 18'h00010; vecs[0].nb[0] = 4'b1110; vecs[0].d[0] = 32'h0000_0011;
    vecs[0].a[1] = 18'h00010; vecs[0].nb[1] = 4'b1101; vecs[0].d[1] = 32'h0000_2200;
    vecs[0].a[2] = 18'h00010; vecs[0].nb[2] = 4'b1011; vecs[0].d[2] = 32'h0033_0000;
    vecs[0].a[3] = 18'h00010; vecs[0].nb[3] = 4'b0111; vecs[0].d[3] = 32'h4400_0000;
    vecs[0].ne = 1;
    vecs[0].e[0] = {18'h00010, 4'b0000, 32'h4433_2211};

    vecs[1] = '0;
    vecs[1].nw = 2;
    vecs[1].a[0] = 18'h00005; vecs[1].nb[0] = 4'b1110; vecs[1].d[0] = 32'h0000_00AA;
    vecs[1].a[1] = 18'h00006; vecs[1].nb[1] = 4'b1110; vecs[1].d[1] = 32'h0000_00BB;
    vecs[1].ne = 2;
    vecs[1].e[0] = {18'h00005, 4'b1110, 32'h0000_00AA};
    vecs[1].e[1] = {18'h00006, 4'b1110, 32'h0000_00BB};

    vecs[2] = '0;
    vecs[2].nw = 2;
    vecs[2].a[0] = 18'h00020; vecs[2].nb[0] = 4'b1100; vecs[2].d[0] = 32'h0000_1122;
    vecs[2].a[1] = 18'h00020; vecs[2].nb[1] = 4'b1110; vecs[2].d[1] = 32'h0000_0033;
    vecs[2].ne = 1;
    vecs[2].e[0] = {18'h00020, 4'b1100, 32'h0000_1133};

    vecs[3] = '0;
    vecs[3].nw = 2;
    vecs[3].a[0] = 18'h00030; vecs[3].nb[0] = 4'b1111; vecs[3].d[0] = 32'hDEAD_BEEF;
    vecs[3].a[1] = 18'h00031; vecs[3].nb[1] = 4'b0011; vecs[3].d[1] = 32'h5566_0000;
    vecs[3].ne = 1;
    vecs[3].e[0] = {18'h00031, 4'b0011, 32'h5566_0000};

    vecs[4] = '0;
    vecs[4].nw = 3;
    vecs[4].a[0] = 18'h00040; vecs[4].nb[0] = 4'b0000; vecs[4].d[0] = 32'h0102_0304;
    vecs[4].a[1] = 18'h00041; vecs[4].nb[1] = 4'b1101; vecs[4].d[1] = 32'h0000_7700;
    vecs[4].a[2] = 18'h00040; vecs[4].nb[2] = 4'b1011; vecs[4].d[2] = 32'h0088_0000;
    vecs[4].ne = 3;
    vecs[4].e[0] = {18'h00040, 4'b0000, 32'h0102_0304};
    vecs[4].e[1] = {18'h00041, 4'b1101, 32'h0000_7700};
    vecs[4].e[2] = {18'h00040, 4'b1011, 32'h0088_0000};

    rst_n     = 1'b0;
    de_req    = 1'b0;
    de_addr   = '0;
    de_nbyte  = 4'b1111;
    de_rnw    = 1'b0;
    de_w_data = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_de_r_data", de_r_data, 0);
    check("rst_mem_rnw", mem_rnw, 0);
    rst_n = 1'b1;

    // Accept latency: de_ack rises one cycle after de_req (ignored all-disabled write).
    @(negedge clk);
    de_req = 1'b1;
    @(negedge clk);
    check("ack_latency", de_ack, 1);
    de_req = 1'b0;
    @(negedge clk);
    check("ignored_not_busy", busy, 0);

    mem_ack = 1'b1;
    for (int i = 0; i < NV; i++) begin
      got_q.delete();
      for (int k = 0; k < 4; k++)
        if (k < int'(vecs[i].nw))
          do_write(vecs[i].a[k], vecs[i].nb[k], vecs[i].d[k], 1'b0);
      drain();
      check($sformatf("v%0d_count", i), got_q.size(), vecs[i].ne);
      for (int k = 0; k < 3; k++)
        if (k < int'(vecs[i].ne))
          check($sformatf("v%0d_entry%0d", i, k),
                (k < got_q.size()) ? got_q[k] : 54'h0, vecs[i].e[k]);
    end

    // Read transfer: flags err, no memory write.
    got_q.delete();
    do_write(18'h00050, 4'b0000, 32'h1234_5678, 1'b1);
    drain();
    check("rnw_err", err, 1);
    check("rnw_no_write", got_q.size(), 0);

    // Partial word stays held until timeout (macro) or flush.
    got_q.delete();
    mem_ack = 1'b0;
    do_write(18'h00060, 4'b1110, 32'h0000_00CC, 1'b0);
    @(negedge clk);
    de_req = 1'b0;
`ifdef WC_TIMEOUT_EN
    repeat (14) @(negedge clk);
    check("timeout_before", mem_req, 0);
    @(negedge clk);
    check("timeout_push", mem_req, 1);
`else
    repeat (20) @(negedge clk);
    check("hold_no_req", mem_req, 0);
    check("hold_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_push", mem_req, 1);
    flush = 1'b0;
`endif
    check("held_addr", mem_addr, 18'h00060);
    check("held_nbyte", mem_nbyte, 4'b1110);
    mem_ack = 1'b1;
    drain();
    check("held_count", got_q.size(), 1);

    // Backpressure: FIFO fills, accepts stop, then drains in order.
    got_q.delete();
    mem_ack = 1'b0;
    fork
      bp_stream();
    join_none
    repeat (20) @(negedge clk);
    check("bp_ack_low", de_ack, 0);
    check("bp_req", mem_req, 1);
    check("bp_head", mem_addr, 18'h00100);
    repeat (3) @(negedge clk);
    check("bp_head_stable", {mem_addr, mem_w_data}, {18'h00100, 32'hA000_0000});
    mem_ack = 1'b1;
    wait fork;
    drain();
    check("bp_count", got_q.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("bp_entry%0d", k), (k < got_q.size()) ? got_q[k] : 54'h0,
            {18'h00100 + 18'(k), 4'b0000, 32'hA000_0000 + 32'(k)});

    // Reset mid-operation with three words queued and one held.
    got_q.delete();
    mem_ack = 1'b0;
    do_write(18'h00200, 4'b0000, 32'hB000_0000, 1'b0);
    do_write(18'h00201, 4'b0000, 32'hB000_0001, 1'b0);
    do_write(18'h00202, 4'b0000, 32'hB000_0002, 1'b0);
    do_write(18'h00203, 4'b1110, 32'h0000_00B3, 1'b0);
    @(negedge clk);
    de_req = 1'b0;
    check("pre_rst_err_sticky", err, 1);
    check("pre_rst_req", mem_req, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_req", mem_req, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_writes", got_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
